// File: rtl/pdp11_int_arb.sv
// Interrupt arbiter sharing the single CPU request line among I/O-page devices.
// Picks the highest-IPL eligible device, presents its vector and runs the ack handshake.
module pdp11_int_arb #(
  parameter int N_DEV = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_DEV-1:0]   dev_int_req,
  input  logic [8*N_DEV-1:0] dev_vector,
  input  logic [3*N_DEV-1:0] dev_ipl,
  input  logic [2:0]         cpu_ipl,
  input  logic               interrupt_ack,
  output logic               interrupt,
  output logic [7:0]         vector,
  output logic [N_DEV-1:0]   dev_ack,
  output logic               busy
);

  localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACK  = 3'd2,
    S_WAIT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] win_idx;
  logic [2:0]       win_ipl;

  logic             any_elig;
  logic [IDX_W-1:0] sel_idx;
  logic [2:0]       sel_ipl;

  // Strict greater-than keeps ties on the lowest index.
  always_comb begin
    any_elig = 1'b0;
    sel_idx  = '0;
    sel_ipl  = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_int_req[i] && (dev_ipl[3*i +: 3] > cpu_ipl)) begin
        if (!any_elig || (dev_ipl[3*i +: 3] > sel_ipl)) begin
          sel_idx = IDX_W'(i);
          sel_ipl = dev_ipl[3*i +: 3];
        end
        any_elig = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      win_idx   <= '0;
      win_ipl   <= '0;
      interrupt <= 1'b0;
      vector    <= '0;
      dev_ack   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_elig) begin
            win_idx   <= sel_idx;
            win_ipl   <= sel_ipl;
            vector    <= dev_vector[8*sel_idx +: 8];
            interrupt <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (interrupt_ack) begin
            interrupt        <= 1'b0;
            dev_ack[win_idx] <= 1'b1;
            state            <= S_ACK;
          end else if (!dev_int_req[win_idx] || (cpu_ipl >= win_ipl)) begin
            interrupt <= 1'b0;
            vector    <= '0;
            state     <= S_IDLE;
          end
        end
        S_ACK: begin
          dev_ack <= '0;
          if (!interrupt_ack) begin
            vector <= '0;
            state  <= S_GAP;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!interrupt_ack) begin
            vector <= '0;
            state  <= S_GAP;
          end
        end
        S_GAP: begin
          vector <= '0;
          state  <= S_IDLE;
        end
        default: begin
          interrupt <= 1'b0;
          vector    <= '0;
          dev_ack   <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_pdp11_int_arb.sv
// Scoreboard bench for pdp11_int_arb: stimulus pushes expected interrupt/ack events,
// a negedge monitor pops and compares them; inline checks cover timing and reset.
module tb_pdp11_int_arb;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   dev_int_req = '0;
  logic [8*N-1:0] dev_vector = '0;
  logic [3*N-1:0] dev_ipl = '0;
  logic [2:0]     cpu_ipl = '0;
  logic           interrupt_ack = 1'b0;
  logic           interrupt;
  logic [7:0]     vector;
  logic [N-1:0]   dev_ack;
  logic           busy;

  pdp11_int_arb #(.N_DEV(N)) dut (
    .clk(clk), .reset(reset), .dev_int_req(dev_int_req), .dev_vector(dev_vector),
    .dev_ipl(dev_ipl), .cpu_ipl(cpu_ipl), .interrupt_ack(interrupt_ack),
    .interrupt(interrupt), .vector(vector), .dev_ack(dev_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_ack;
    logic [3:0] ack;
    logic [7:0] vec;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_int(input logic [7:0] vec);
    ev_t e;
    e.is_ack = 1'b0; e.ack = '0; e.vec = vec;
    exp_q.push_back(e);
  endtask

  task automatic push_ack(input logic [3:0] a, input logic [7:0] vec);
    ev_t e;
    e.is_ack = 1'b1; e.ack = a; e.vec = vec;
    exp_q.push_back(e);
  endtask

  task automatic set_dev(input int i, input logic [2:0] ipl, input logic [7:0] vec);
    dev_ipl[3*i +: 3]    = ipl;
    dev_vector[8*i +: 8] = vec;
  endtask

  // Monitor: a rising interrupt or any dev_ack pulse is a DUT event to score.
  logic prev_int = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (interrupt && !prev_int) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_int: vector %0o with nothing expected", vector);
      end else begin
        e = exp_q.pop_front();
        chk("int_event_kind", 32'(e.is_ack), 32'd0);
        chk("int_vector", 32'(vector), 32'(e.vec));
      end
    end
    if (dev_ack != '0) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_dev_ack: dev_ack %b with nothing expected", dev_ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_event_kind", 32'(e.is_ack), 32'd1);
        chk("ack_dev_ack", 32'(dev_ack), 32'(e.ack));
        chk("ack_vector", 32'(vector), 32'(e.vec));
      end
    end
    prev_int = interrupt;
  end

  // Call with the winning request already applied; runs grant, ack held `hold` edges, release.
  task automatic grant_and_ack(input logic [3:0] onehot, input logic [7:0] vec, input int hold);
    push_int(vec);
    tick(1);
    chk("grant_interrupt", 32'(interrupt), 32'd1);
    chk("grant_vector", 32'(vector), 32'(vec));
    interrupt_ack = 1'b1;
    push_ack(onehot, vec);
    tick(1);
    chk("ack_pulse", 32'(dev_ack), 32'(onehot));
    chk("ack_int_low", 32'(interrupt), 32'd0);
    dev_int_req = dev_int_req & ~onehot;
    if (hold > 1) begin
      tick(hold - 1);
      chk("ack_one_cycle", 32'(dev_ack), 32'd0);
      chk("hold_vector", 32'(vector), 32'(vec));
    end
    interrupt_ack = 1'b0;
    tick(1);
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_int", 32'(interrupt), 32'd0);
    tick(1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_vector", 32'(vector), 32'd0);
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    chk("rst_vector", 32'(vector), 32'd0);
    chk("rst_dev_ack", 32'(dev_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single request, ack held three edges
    set_dev(3, 3'd4, 8'o64);
    dev_int_req[3] = 1'b1;
    grant_and_ack(4'b1000, 8'o64, 3);

    // Priority: higher ipl wins regardless of index
    set_dev(1, 3'd5, 8'o220);
    set_dev(2, 3'd6, 8'o100);
    dev_int_req = 4'b0110;
    grant_and_ack(4'b0100, 8'o100, 1);
    dev_int_req = '0;

    // Tie at ipl 4: lowest index wins
    set_dev(0, 3'd4, 8'o60);
    set_dev(1, 3'd4, 8'o220);
    set_dev(2, 3'd4, 8'o100);
    dev_int_req = 4'b0111;
    grant_and_ack(4'b0001, 8'o60, 2);
    dev_int_req = '0;

    // Masking: equal ipl is masked, one level higher is taken
    cpu_ipl = 3'd4;
    set_dev(0, 3'd4, 8'o60);
    dev_int_req = 4'b0001;
    tick(3);
    chk("masked_int", 32'(interrupt), 32'd0);
    chk("masked_busy", 32'(busy), 32'd0);
    set_dev(0, 3'd5, 8'o60);
    grant_and_ack(4'b0001, 8'o60, 2);
    dev_int_req = '0;
    cpu_ipl = 3'd0;

    // Withdrawal in REQ
    set_dev(1, 3'd5, 8'o220);
    dev_int_req = 4'b0010;
    push_int(8'o220);
    tick(1);
    chk("wd_int_up", 32'(interrupt), 32'd1);
    dev_int_req = '0;
    tick(1);
    chk("wd_int", 32'(interrupt), 32'd0);
    chk("wd_vector", 32'(vector), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    tick(1);
    chk("wd_no_ack", 32'(dev_ack), 32'd0);

    // Mask raised to 7 in REQ
    dev_int_req = 4'b0010;
    push_int(8'o220);
    tick(1);
    chk("mr_int_up", 32'(interrupt), 32'd1);
    cpu_ipl = 3'd7;
    tick(1);
    chk("mr_int", 32'(interrupt), 32'd0);
    chk("mr_vector", 32'(vector), 32'd0);
    tick(1);
    chk("mr_stay_idle", 32'(busy), 32'd0);
    dev_int_req = '0;
    cpu_ipl = 3'd0;

    // No preemption, then back-to-back grant two cycles after ack falls
    set_dev(2, 3'd4, 8'o110);
    set_dev(0, 3'd7, 8'o244);
    dev_int_req = 4'b0100;
    push_int(8'o110);
    tick(1);
    dev_int_req[0] = 1'b1;
    tick(2);
    chk("np_vector", 32'(vector), 32'(8'o110));
    chk("np_int", 32'(interrupt), 32'd1);
    interrupt_ack = 1'b1;
    push_ack(4'b0100, 8'o110);
    tick(1);
    chk("np_ack", 32'(dev_ack), 32'(4'b0100));
    dev_int_req[2] = 1'b0;
    tick(1);
    interrupt_ack = 1'b0;
    push_int(8'o244);
    tick(1);
    chk("b2b_gap_int", 32'(interrupt), 32'd0);
    tick(1);
    chk("b2b_idle_int", 32'(interrupt), 32'd0);
    tick(1);
    chk("b2b_int", 32'(interrupt), 32'd1);
    chk("b2b_vector", 32'(vector), 32'(8'o244));
    interrupt_ack = 1'b1;
    push_ack(4'b0001, 8'o244);
    tick(1);
    dev_int_req = '0;
    interrupt_ack = 1'b0;
    tick(2);
    chk("b2b_done", 32'(busy), 32'd0);

    // Reset while in ACK
    set_dev(3, 3'd4, 8'o64);
    dev_int_req = 4'b1000;
    push_int(8'o64);
    tick(1);
    interrupt_ack = 1'b1;
    push_ack(4'b1000, 8'o64);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("ra_interrupt", 32'(interrupt), 32'd0);
    chk("ra_vector", 32'(vector), 32'd0);
    chk("ra_dev_ack", 32'(dev_ack), 32'd0);
    chk("ra_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    dev_int_req = '0;
    interrupt_ack = 1'b0;
    tick(2);
    chk("ra_after", 32'({busy, interrupt, dev_ack}), 32'd0);

    // Reset while in WAIT
    dev_int_req = 4'b1000;
    push_int(8'o64);
    tick(1);
    interrupt_ack = 1'b1;
    push_ack(4'b1000, 8'o64);
    tick(1);
    dev_int_req = '0;
    tick(1);
    chk("rw_in_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(1);
    chk("rw_interrupt", 32'(interrupt), 32'd0);
    chk("rw_vector", 32'(vector), 32'd0);
    chk("rw_dev_ack", 32'(dev_ack), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    interrupt_ack = 1'b0;
    tick(3);
    chk("rw_after", 32'({busy, interrupt, dev_ack}), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
